alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
//------------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue controller for an external, fixed-latency ALU. It owns a 16 x 16-bit
// register file, where r0 always reads 0. One instruction is accepted at a time.
// Its operands are held on the ALU ports for ALU_LAT cycles. The ALU result is
// then written back, and a one-cycle done pulse is raised.
//
// Parameters
//   ALU_LAT      cycles the operands are held before alu_result is sampled (1-4)
//
// Optional feature (compile-time macro)
//   ALU_CARRY_FLAG_EN  op 4'hF becomes SETC: it loads a carry flag from rb[0].
//                      The flag drives cin/bin while an instruction is issued.
//                      Undefined: op 4'hF is an ordinary ALU op, cin=bin=0.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   instr_valid  instruction word present
//   instr[15:0]  {op[15:12], rd[11:8], ra[7:4], rb[3:0]}
//   instr_ready  controller can accept an instruction (IDLE, no load, no reset)
//   ld_valid     direct register-file load strobe (honoured in IDLE only)
//   ld_addr[3:0] load destination register
//   ld_data[15:0] load value
//   op_code[3:0] ALU opcode (0 outside ISSUE)
//   rs1_in/rs2_in[15:0] ALU operands (0 outside ISSUE)
//   cin, bin     ALU carry-in / borrow-in (0 outside ISSUE)
//   alu_result[15:0] ALU result, sampled at the end of the last ISSUE cycle
//   done         one-cycle write-back pulse
//   wb_addr[3:0], wb_data[15:0] destination and value written, valid with done
//------------------------------------------------------------------------------
module alu_issue_ctrl #(
   parameter int ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   input  logic        ld_valid,
   input  logic [3:0]  ld_addr,
   input  logic [15:0] ld_data,
   output logic [3:0]  op_code,
   output logic [15:0] rs1_in,
   output logic [15:0] rs2_in,
   output logic        cin,
   output logic        bin,
   input  logic [15:0] alu_result,
   output logic        done,
   output logic [3:0]  wb_addr,
   output logic [15:0] wb_data
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WB    = 2'd2
   } state_t;

   // Counter value reached in the final ISSUE cycle
   localparam logic [1:0] LAST_CNT = 2'(ALU_LAT - 1);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [1:0]  cnt_r;

   logic [15:0] rf_r [0:15];

   logic [3:0]  op_r;
   logic [15:0] rs1_r;
   logic [15:0] rs2_r;
   logic [3:0]  rd_r;
   logic        cin_r;

   logic        done_r;
   logic [3:0]  wb_addr_r;
   logic [15:0] wb_data_r;

   logic        ready_s;
   logic        accept_s;
   logic        issue_last_s;
   logic        ld_en_s;
   logic        wb_we_s;
   logic        is_setc_s;
   logic        carry_s;

   logic [3:0]  dec_op_s;
   logic [3:0]  dec_rd_s;
   logic [3:0]  dec_ra_s;
   logic [3:0]  dec_rb_s;
   logic [15:0] rd_ra_s;
   logic [15:0] rd_rb_s;

   // Instruction field decode and register-file read ports (r0 reads as zero)
   always_comb begin
      dec_op_s = instr[15:12];
      dec_rd_s = instr[11:8];
      dec_ra_s = instr[7:4];
      dec_rb_s = instr[3:0];
      if (dec_ra_s == 4'd0) begin
         rd_ra_s = 16'd0;
      end else begin
         rd_ra_s = rf_r[dec_ra_s];
      end
      if (dec_rb_s == 4'd0) begin
         rd_rb_s = 16'd0;
      end else begin
         rd_rb_s = rf_r[dec_rb_s];
      end
   end

`ifdef ALU_CARRY_FLAG_EN
   logic carry_r;

   // Carry flag: loaded from rb[0] when a SETC is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_r <= 1'b0;
      end else if (accept_s && is_setc_s) begin
         carry_r <= dec_rb_s[0];
      end
   end

   // SETC detection and carry flag source
   always_comb begin
      carry_s   = carry_r;
      is_setc_s = (dec_op_s == 4'hF);
   end
`else
   // No carry flag: every opcode is an ALU op and carry-in is always zero
   always_comb begin
      carry_s   = 1'b0;
      is_setc_s = 1'b0;
   end
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; SETC skips ISSUE and goes straight to write-back
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (is_setc_s) begin
                  state_nxt_s = ST_WB;
               end else begin
                  state_nxt_s = ST_ISSUE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (issue_last_s) begin
               state_nxt_s = ST_WB;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_WB: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: handshake and register-file write enables
   always_comb begin
      ready_s      = 1'b0;
      ld_en_s      = 1'b0;
      issue_last_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A load in the same cycle takes priority over accepting an instruction
            ready_s = !ld_valid && !rst;
            ld_en_s = ld_valid && (ld_addr != 4'd0);
         end
         ST_ISSUE: begin
            issue_last_s = (cnt_r == LAST_CNT);
         end
         ST_WB: begin
            ready_s = 1'b0;
         end
         default: begin
            ready_s = 1'b0;
         end
      endcase
      accept_s = instr_valid && ready_s;
      wb_we_s  = issue_last_s && (rd_r != 4'd0);
   end

   // ISSUE cycle counter, restarted on every accept
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= 2'd0;
      end else if (accept_s) begin
         cnt_r <= 2'd0;
      end else if ((state_r == ST_ISSUE) && !issue_last_s) begin
         cnt_r <= cnt_r + 2'd1;
      end else begin
         cnt_r <= 2'd0;
      end
   end

   // Operand registers double as the ALU port drivers; they are cleared when
   // ISSUE ends, so the ALU ports read zero in IDLE and WB
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r  <= 4'd0;
         rs1_r <= 16'd0;
         rs2_r <= 16'd0;
         rd_r  <= 4'd0;
         cin_r <= 1'b0;
      end else if (accept_s && !is_setc_s) begin
         op_r  <= dec_op_s;
         rs1_r <= rd_ra_s;
         rs2_r <= rd_rb_s;
         rd_r  <= dec_rd_s;
         cin_r <= carry_s;
      end else if (issue_last_s) begin
         op_r  <= 4'd0;
         rs1_r <= 16'd0;
         rs2_r <= 16'd0;
         cin_r <= 1'b0;
      end
   end

   // Write-back report registers and the done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         done_r    <= 1'b0;
         wb_addr_r <= 4'd0;
         wb_data_r <= 16'd0;
      end else if (issue_last_s) begin
         done_r    <= 1'b1;
         wb_addr_r <= rd_r;
         wb_data_r <= alu_result;
      end else if (accept_s && is_setc_s) begin
         done_r    <= 1'b1;
         wb_addr_r <= 4'd0;
         wb_data_r <= 16'd0;
      end else begin
         done_r    <= 1'b0;
      end
   end

   // Register file: ALU write-back (ISSUE only) and load port (IDLE only)
   // never coincide, because they are enabled in different states
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            rf_r[i] <= 16'd0;
         end
      end else if (wb_we_s) begin
         rf_r[rd_r] <= alu_result;
      end else if (ld_en_s) begin
         rf_r[ld_addr] <= ld_data;
      end
   end

   assign instr_ready = ready_s;
   assign op_code     = op_r;
   assign rs1_in      = rs1_r;
   assign rs2_in      = rs2_r;
   assign cin         = cin_r;
   assign bin         = cin_r;
   assign done        = done_r;
   assign wb_addr     = wb_addr_r;
   assign wb_data     = wb_data_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
//------------------------------------------------------------------------------
// Bench for alu_issue_ctrl. Two instances, one with ALU_LAT=1 and one with
// ALU_LAT=3, share the stimulus and have separate resets. Each instance has
// an ALU model: rs1 + rs2 + cin. Stimulus pushes expected issue windows and
// write-backs into a queue for each instance. A monitor pops and compares on
// every done pulse. Outside issue windows, the monitor checks that the ALU
// ports read zero.
//------------------------------------------------------------------------------
module tb_alu_issue_ctrl;

   typedef struct {
      int          acc;
      int          iss_end;
      int          done_cyc;   // 0: aborted, no write-back expected
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [3:0]  wa;
      logic [15:0] wd;
   } exp_t;

   logic        clk;
   logic        rst1, rst3;
   logic        instr_valid;
   logic [15:0] instr;
   logic        ld_valid;
   logic [3:0]  ld_addr;
   logic [15:0] ld_data;

   logic        ready1, ready3;
   logic [3:0]  op1, op3;
   logic [15:0] a1, a3, b1, b3;
   logic        ci1, ci3, bi1, bi3;
   logic [15:0] res1, res3;
   logic        done1, done3;
   logic [3:0]  wa1, wa3;
   logic [15:0] wd1, wd3;

   int          cyc;
   int          n_checks;
   int          n_errors;
   logic        mon_en;
   exp_t        q0[$];
   exp_t        q1[$];
   logic [15:0] rf [2][16];
   logic        carry [2];

   assign res1 = a1 + b1 + {15'd0, ci1};
   assign res3 = a3 + b3 + {15'd0, ci3};

   alu_issue_ctrl #(.ALU_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst1), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(ready1), .ld_valid(ld_valid), .ld_addr(ld_addr),
      .ld_data(ld_data), .op_code(op1), .rs1_in(a1), .rs2_in(b1),
      .cin(ci1), .bin(bi1), .alu_result(res1), .done(done1),
      .wb_addr(wa1), .wb_data(wd1));

   alu_issue_ctrl #(.ALU_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst3), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(ready3), .ld_valid(ld_valid), .ld_addr(ld_addr),
      .ld_data(ld_data), .op_code(op3), .rs1_in(a3), .rs2_in(b3),
      .cin(ci3), .bin(bi3), .alu_result(res3), .done(done3),
      .wb_addr(wa3), .wb_data(wd3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Build the expected response of instance d for an instruction presented in cycle c
   task automatic push_exp(input int d, input int c, input logic [15:0] w);
      exp_t e;
      int   lat;
      lat = (d == 0) ? 1 : 3;
      e.acc = c;
      e.op  = w[15:12];
      e.a   = (w[7:4] == 4'd0) ? 16'd0 : rf[d][w[7:4]];
      e.b   = (w[3:0] == 4'd0) ? 16'd0 : rf[d][w[3:0]];
`ifdef ALU_CARRY_FLAG_EN
      e.ci  = carry[d];
      if (w[15:12] == 4'hF) begin
         e.iss_end  = c;
         e.done_cyc = c + 1;
         e.op = 4'd0; e.a = 16'd0; e.b = 16'd0; e.ci = 1'b0;
         e.wa = 4'd0; e.wd = 16'd0;
         carry[d] = w[0];
         if (d == 0) q0.push_back(e); else q1.push_back(e);
         return;
      end
`else
      e.ci  = 1'b0;
`endif
      e.iss_end  = c + lat;
      e.done_cyc = c + lat + 1;
      e.wa = w[11:8];
      e.wd = e.a + e.b + {15'd0, e.ci};
      if (w[11:8] != 4'd0) rf[d][w[11:8]] = e.wd;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   // Per-cycle monitor for one instance
   task automatic mon(input int d, input logic dn, input logic [3:0] op,
                      input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic bi, input logic [3:0] wa, input logic [15:0] wd);
      exp_t e;
      logic have;
      string tag;
      tag = (d == 0) ? "lat1" : "lat3";
      // drop aborted entries once their truncated issue window has passed
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) begin
         e = (d == 0) ? q0[0] : q1[0];
         if (e.done_cyc == 0 && cyc > e.iss_end) begin
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (have) e = (d == 0) ? q0[0] : q1[0];
         end
      end
      if (have && cyc > e.acc && cyc <= e.iss_end) begin
         chk({tag, " issue ports"}, {op, a, bi, ci}, {e.op, e.a, e.ci, e.ci});
         chk({tag, " issue b"}, {16'd0, b}, {16'd0, e.b});
      end else begin
         chk({tag, " idle ports zero"}, {op, a, bi, ci}, 22'd0);
         chk({tag, " idle b zero"}, {16'd0, b}, 32'd0);
      end
      if (dn) begin
         if (have && e.done_cyc == cyc) begin
            chk({tag, " writeback"}, {wa, wd}, {e.wa, e.wd});
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end else begin
            chk({tag, " unexpected done"}, 32'd1, 32'd0);
         end
      end else if (have && e.done_cyc != 0 && cyc > e.done_cyc) begin
         chk({tag, " missing done"}, 32'd0, 32'd1);
         if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
   endtask

   always begin
      @(negedge clk);
      #1;
      if (mon_en) begin
         mon(0, done1, op1, a1, b1, ci1, bi1, wa1, wd1);
         mon(1, done3, op3, a3, b3, ci3, bi3, wa3, wd3);
      end
   end

   // Single instruction presented for one cycle; returns five cycles later (both idle)
   task automatic issue(input logic [3:0] op, input logic [3:0] rd,
                        input logic [3:0] ra, input logic [3:0] rb);
      int c;
      c = cyc;
      instr = {op, rd, ra, rb};
      instr_valid = 1'b1;
      push_exp(0, c, instr);
      push_exp(1, c, instr);
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic load(input logic [3:0] addr, input logic [15:0] data);
      ld_valid = 1'b1;
      ld_addr  = addr;
      ld_data  = data;
      #1;
      chk("ready low during load lat1", {31'd0, ready1}, 32'd0);
      chk("ready low during load lat3", {31'd0, ready3}, 32'd0);
      if (addr != 4'd0) begin
         rf[0][addr] = data;
         rf[1][addr] = data;
      end
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   initial begin
      int c;
      cyc = 0; n_checks = 0; n_errors = 0; mon_en = 1'b0;
      rst1 = 1'b1; rst3 = 1'b1;
      instr_valid = 1'b0; instr = 16'd0;
      ld_valid = 1'b0; ld_addr = 4'd0; ld_data = 16'd0;
      for (int d = 0; d < 2; d++) begin
         carry[d] = 1'b0;
         for (int r = 0; r < 16; r++) rf[d][r] = 16'd0;
      end

      // reset and default outputs
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("ready low in reset lat1", {31'd0, ready1}, 32'd0);
      chk("ready low in reset lat3", {31'd0, ready3}, 32'd0);
      rst1 = 1'b0; rst3 = 1'b0;
      #1;
      chk("reset ready/done lat1", {30'd0, ready1, done1}, 32'd2);
      chk("reset ready/done lat3", {30'd0, ready3, done3}, 32'd2);
      chk("reset wb lat1", {12'd0, wa1, wd1}, 32'd0);
      chk("reset wb lat3", {12'd0, wa3, wd3}, 32'd0);
      mon_en = 1'b1;

      // every register reads back zero after reset
      for (int r = 1; r < 16; r++) issue(4'h0, 4'd0, 4'(r), 4'd0);

      // basic issue
      load(4'd1, 16'd6);
      load(4'd2, 16'h4001);
      issue(4'h2, 4'd3, 4'd1, 4'd2);

      // instr_valid held for 10 cycles: accepts every ALU_LAT+2 cycles
      c = cyc;
      instr = {4'h2, 4'd3, 4'd1, 4'd2};
      instr_valid = 1'b1;
      for (int k = 0; k * 3 <= 9; k++) push_exp(0, c + k * 3, instr);
      for (int k = 0; k * 5 <= 9; k++) push_exp(1, c + k * 5, instr);
      repeat (10) @(negedge clk);
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);

      // load and instruction together: load only
      instr = {4'h2, 4'd6, 4'd1, 4'd2};
      instr_valid = 1'b1;
      load(4'd4, 16'h1234);
      instr_valid = 1'b0;
      repeat (4) @(negedge clk);
      issue(4'h0, 4'd7, 4'd4, 4'd0);
      issue(4'h0, 4'd8, 4'd6, 4'd0);

      // rd = ra: operands are pre-write values
      load(4'd1, 16'd5);
      load(4'd2, 16'd5);
      issue(4'h1, 4'd1, 4'd1, 4'd2);
      issue(4'h0, 4'd9, 4'd1, 4'd0);

      // r0 ignores loads and write-backs
      load(4'd0, 16'hFFFF);
      issue(4'h2, 4'd0, 4'd1, 4'd2);
      issue(4'h0, 4'd10, 4'd0, 4'd0);

      // op 4'hF: SETC with the carry flag, otherwise an ordinary ALU op
      issue(4'hF, 4'd0, 4'd0, 4'd1);
      load(4'd12, 16'd6);
      load(4'd13, 16'd1);
      issue(4'h2, 4'd14, 4'd12, 4'd13);
      issue(4'h0, 4'd11, 4'd14, 4'd0);

      // reset the ALU_LAT=3 instance in its second ISSUE cycle
      c = cyc;
      instr = {4'h2, 4'd5, 4'd12, 4'd13};
      instr_valid = 1'b1;
      push_exp(0, c, instr);
      begin
         exp_t e;
         e.acc = c; e.iss_end = c + 2; e.done_cyc = 0;
         e.op = 4'h2; e.a = rf[1][12]; e.b = rf[1][13];
`ifdef ALU_CARRY_FLAG_EN
         e.ci = carry[1];
`else
         e.ci = 1'b0;
`endif
         e.wa = 4'd5; e.wd = 16'd0;
         q1.push_back(e);
      end
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst3 = 1'b1;
      #1;
      chk("ready low during mid-issue reset", {31'd0, ready3}, 32'd0);
      @(negedge clk);
      rst3 = 1'b0;
      carry[1] = 1'b0;
      for (int r = 0; r < 16; r++) rf[1][r] = 16'd0;
      #1;
      chk("ready after mid-issue reset", {31'd0, ready3}, 32'd1);
      repeat (2) @(negedge clk);
      issue(4'h0, 4'd9, 4'd5, 4'd0);
      issue(4'h0, 4'd9, 4'd12, 4'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard drained lat1", q0.size(), 32'd0);
      chk("scoreboard drained lat3", q1.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
